// File: rtl/prio_grant_pkg.sv
// Shared types and helpers for the priority grant encoder.
package prio_grant_pkg;

   // Handshake FSM states
   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   // Index width that never collapses below one bit
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational winner selection: rotate so the search start sits at the top,
// pick the highest set bit, then map back to the original index modulo N.
module prio_pick
   import prio_grant_pkg::*;
#(
   parameter  int unsigned N = 8,
   localparam int unsigned W = clog2_min1(N)
) (
   input  logic [N-1:0] elig,
   input  logic [W-1:0] start,
   input  logic         rr_mode,
   output logic         any,
   output logic [W-1:0] winner
);

   logic [W-1:0]   off;
   logic [W:0]     start_inc;
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W-1:0]   hi;
   logic [W:0]     sum;

   // Rotation offset: start+1 mod N in round-robin, zero (plain order) otherwise
   always_comb begin
      off       = '0;
      start_inc = {1'b0, start} + (W+1)'(1);
      if (rr_mode && (start_inc < (W+1)'(N))) begin
         off = start_inc[W-1:0];
      end
   end

   // Rotate right by the offset so elig[start] lands at position N-1
   always_comb begin
      dbl = {elig, elig} >> off;
      rot = dbl[N-1:0];
   end

   // Highest set bit of the rotated vector
   always_comb begin
      any = 1'b0;
      hi  = '0;
      for (int unsigned j = 0; j < N; j++) begin
         if (rot[j]) begin
            hi  = W'(j);
            any = 1'b1;
         end
      end
   end

   // Undo the rotation with a single conditional subtract (handles any N)
   always_comb begin
      sum = {1'b0, hi} + {1'b0, off};
      if (sum >= (W+1)'(N)) begin
         sum = sum - (W+1)'(N);
      end
      winner = sum[W-1:0];
   end

endmodule

// File: rtl/prio_grant_encoder.sv
// Registered N-input priority encoder with pending latch, per-line mask and
// fixed / round-robin arbitration, offering one index at a time on valid/ready.
module prio_grant_encoder
   import prio_grant_pkg::*;
#(
   parameter  int unsigned N = 8,
   localparam int unsigned W = clog2_min1(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         rr_mode,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] idx,
   output logic [N-1:0] pending
);

   state_t       state;
   state_t       state_nx;
   logic [N-1:0] pending_nx;
   logic [N-1:0] clr;
   logic [N-1:0] elig;
   logic [W-1:0] last;
   logic [W-1:0] last_nx;
   logic [W-1:0] start;
   logic [W-1:0] idx_nx;
   logic         valid_nx;
   logic         any;
   logic [W-1:0] winner;

   // Eligible lines and round-robin search start (last-1 mod N)
   always_comb begin
      elig  = pending & ~mask;
      start = (last == '0) ? W'(N - 1) : last - W'(1);
   end

   prio_pick #(
      .N (N)
   ) u_pick (
      .elig    (elig),
      .start   (start),
      .rr_mode (rr_mode),
      .any     (any),
      .winner  (winner)
   );

   // Accepting the offer clears the offered line; a same-cycle request re-sets it
   always_comb begin
      clr = '0;
      if ((state == OFFER) && ready) begin
         clr = N'(1) << idx;
      end
      pending_nx = req | (pending & ~clr);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any)   state_nx = OFFER;
         OFFER:   if (ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values for the registered outputs and the round-robin pointer
   always_comb begin
      valid_nx = valid;
      idx_nx   = idx;
      last_nx  = last;
      case (state)
         IDLE: begin
            if (any) begin
               valid_nx = 1'b1;
               idx_nx   = winner;
            end
         end
         OFFER: begin
            if (ready) begin
               valid_nx = 1'b0;
               last_nx  = idx;
            end
         end
         default: valid_nx = 1'b0;
      endcase
   end

   // Output, pending and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         idx     <= '0;
         last    <= '0;
         pending <= '0;
      end else begin
         valid   <= valid_nx;
         idx     <= idx_nx;
         last    <= last_nx;
         pending <= pending_nx;
      end
   end

endmodule

// File: doc/prio_grant_encoder.md
Name: prio_grant_encoder

Overview:
- Parametrised, registered N-input priority encoder with a pending latch, per-line mask, and fixed or round-robin arbitration.
- Offers one winning index at a time on a valid/ready handshake. The consumer acknowledges each index, and that clears the pending bit.
- Sits between raw request/status lines and a sequential consumer, such as an interrupt dispatcher or a shared-resource sequencer.

Parameters:
- N, 8, number of request lines; legal range 2..64.
- W, $clog2(N), index width; derived, never overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronous deassert assumed upstream.
- req  in  N  request lines; level-sampled every cycle.
- mask  in  N  1 = line excluded from arbitration; its pending bit is still kept.
- rr_mode  in  1  0 = fixed priority (index N-1 highest); 1 = round-robin.
- ready  in  1  consumer accepts the offered index.
- valid  out  1  an index is being offered.
- idx  out  W  offered index; meaningful only while valid=1.
- pending  out  N  current pending register, for status/debug.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pending=0, valid=0, idx=0, last=0, state=IDLE.
  - Takes effect immediately, including mid-offer; a pending offer is discarded.
- Pending register, per bit i, each edge:
  - pending[i] <= req[i] | (pending[i] & ~clr[i]).
  - clr = onehot(idx) when state=OFFER && ready, else 0.
  - If set and clear coincide, set wins.
- Eligibility: elig = pending & ~mask.
- Fixed mode: winner = highest set index of elig.
- Round-robin mode:
  - Search starts at (last-1) mod N and descends with wrap-around; index last has lowest priority.
  - last resets to 0, so the first round-robin search order equals fixed order.
- FSM, two states:
  - IDLE: valid=0. If elig != 0, register idx <= winner and valid <= 1, go to OFFER. Else stay.
  - OFFER: valid=1, idx held stable. When ready=1 at an edge: clear pending[idx], last <= idx, valid <= 0, go to IDLE. When ready=0: hold idx and valid. No withdrawal, even if the line becomes masked or a higher-priority request arrives.
- Latency: req high at edge k sets pending at edge k; valid=1 with the corresponding idx after edge k+1, if that request wins.
- Throughput: at most one grant per 2 cycles (one IDLE bubble after each accept). This is fixed and must not be optimised away.
- rr_mode and mask are sampled only in IDLE; changes during OFFER take effect at the next IDLE evaluation.
- No requests: valid=0, idx holds its last value. Idle idx value is don't-care for consumers, but the bench checks the hold behaviour.
- Level sources must deassert req before or on the accept edge. A still-high req re-pends the line, which is intended.
- All outputs registered; no combinational path from req/mask/ready to valid/idx.

Decomposition:
- Package prio_grant_pkg:
  - state enum {IDLE, OFFER}.
  - Function clog2_min1(N), giving W >= 1.
- Sub-module prio_pick (combinational):
  - Inputs: elig[N], start[W], rr_mode.
  - Outputs: any, winner[W].
  - Implementation: rotate, find highest set bit, un-rotate modulo N; handles non-power-of-2 N.
- The top level holds the pending register, FSM, last pointer and output registers.

Test Plan (N=8):
- Reset: drive rst_n=0 mid-offer with valid=1, idx=5 -> valid and pending drop to 0 in the same cycle, without waiting for clk. After release with req=0: valid stays 0.
- Fixed priority: rr_mode=0, ready=1, one-cycle req=8'b0010_0100 -> grants idx=5 then idx=2, two cycles apart. Then valid=0; pending=8'h24->8'h04->8'h00.
- Backpressure: ready=0 while idx=5 offered, then pulse req bit 7 -> idx stays 5 and valid stays 1 for 10 cycles. Raise ready -> accept 5, next offer idx=7.
- Mask: mask=8'h80, req pulse 8'h81 -> offers idx=0 only; pending stays 8'h80. Clear mask -> offers idx=7.
- Round-robin: req held at 8'h11, ready=1. rr_mode=1 -> idx sequence 4,0,4,0. rr_mode=0 -> 4,4,4.
- Collision and wrap: with req bit 3 held high across its accept edge -> pending[3] remains 1 and idx=3 is re-offered. In rr mode with last=0 and elig=8'h01 -> idx=0 is granted after a full wrap.
